// File: rtl/arb_rr4_demux_ctrl.sv
// Round-robin 4:1 arbiter feeding the 1:2 demux; tracks target lane, stalls on almost-full.
// Optional burst grants: define ARB_BURST_EN.
module arb_rr4_demux_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              arb_en,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  input  logic [1:0]        dest_af,
  output logic [3:0]        fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out,
  output logic [1:0]        grant_id,
  output logic [1:0]        state_out,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("BURST_LEN must be 1..15");
  end

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              next_lane_q, next_lane_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              lane_q, lane_d;
  logic [1:0]        gid_q, gid_d;
  logic [7:0]        stall_q, stall_d;

  logic [3:0]        req;
  logic              any_req;
  logic              blocked;
  logic              grant_v;
  logic [7:0]        dbl;
  logic [3:0]        rot;
  logic [1:0]        off;
  logic [1:0]        g;
  logic [DATA_W-1:0] word;

`ifdef ARB_BURST_EN
  logic [3:0] burst_q, burst_d;
  logic [3:0] burst_base;
  logic [3:0] burst_nx;
`endif

  // Rotate requests so the scan always starts at ptr.
  always_comb begin
    req     = reset_L ? (~fifo_empty & {4{arb_en}}) : 4'b0000;
    any_req = |req;
    blocked = dest_af[next_lane_q];
    grant_v = any_req & ~blocked;
    dbl     = {req, req} >> ptr_q;
    rot     = dbl[3:0];
    off     = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    g        = ptr_q + off;
    fifo_pop = grant_v ? (4'b0001 << g) : 4'b0000;
    word     = fifo_data0;
    unique case (g)
      2'd0: word = fifo_data0;
      2'd1: word = fifo_data1;
      2'd2: word = fifo_data2;
      2'd3: word = fifo_data3;
      default: word = fifo_data0;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = grant_v;
    lane_d      = lane_q;
    gid_d       = gid_q;
    next_lane_d = next_lane_q;
    ptr_d       = ptr_q;
    stall_d     = stall_q;
`ifdef ARB_BURST_EN
    burst_d     = burst_q;
    burst_base  = 4'd0;
    burst_nx    = 4'd0;
`endif
    if (grant_v) begin
      data_d      = word;
      gid_d       = g;
      lane_d      = next_lane_q;
      next_lane_d = ~next_lane_q;
`ifdef ARB_BURST_EN
      burst_base = (g == ptr_q) ? burst_q : 4'd0;
      burst_nx   = burst_base + 4'd1;
      if (burst_nx >= 4'(BURST_LEN)) begin
        ptr_d   = g + 2'd1;
        burst_d = 4'd0;
      end else begin
        ptr_d   = g;
        burst_d = burst_nx;
      end
    end else if (burst_q != 4'd0 && !req[ptr_q]) begin
      ptr_d   = ptr_q + 2'd1;
      burst_d = 4'd0;
`else
      ptr_d = g + 2'd1;
`endif
    end
    if (any_req && blocked && stall_q != 8'hFF) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_v)                 state_d = ACTIVE;
        else if (any_req && blocked) state_d = STALL;
      end
      ACTIVE: begin
        if (!any_req)     state_d = IDLE;
        else if (blocked) state_d = STALL;
      end
      STALL: begin
        if (grant_v)       state_d = ACTIVE;
        else if (!any_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      next_lane_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      lane_q      <= 1'b0;
      gid_q       <= 2'd0;
      stall_q     <= 8'd0;
`ifdef ARB_BURST_EN
      burst_q     <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      next_lane_q <= next_lane_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      lane_q      <= lane_d;
      gid_q       <= gid_d;
      stall_q     <= stall_d;
`ifdef ARB_BURST_EN
      burst_q     <= burst_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign grant_id  = gid_q;
  assign state_out = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_arb_rr4_demux_ctrl.sv
// Directed bench for arb_rr4_demux_ctrl with queue-modelled requester FIFOs.
// Burst step is included when ARB_BURST_EN is defined.
module tb_arb_rr4_demux_ctrl;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       arb_en;
  logic [3:0] fifo_empty;
  logic [7:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
  logic [1:0] dest_af;
  logic [3:0] fifo_pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic [1:0] grant_id;
  logic [1:0] state_out;
  logic [7:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  arb_rr4_demux_ctrl #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .arb_en     (arb_en),
    .fifo_empty (fifo_empty),
    .fifo_data0 (fifo_data0),
    .fifo_data1 (fifo_data1),
    .fifo_data2 (fifo_data2),
    .fifo_data3 (fifo_data3),
    .dest_af    (dest_af),
    .fifo_pop   (fifo_pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_out   (lane_out),
    .grant_id   (grant_id),
    .state_out  (state_out),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    fifo_empty = {q3.size() == 0, q2.size() == 0,
                  q1.size() == 0, q0.size() == 0};
    fifo_data0 = (q0.size() != 0) ? q0[0] : 8'h00;
    fifo_data1 = (q1.size() != 0) ? q1[0] : 8'h00;
    fifo_data2 = (q2.size() != 0) ? q2[0] : 8'h00;
    fifo_data3 = (q3.size() != 0) ? q3[0] : 8'h00;
  endtask

  task automatic clrq();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    upd();
  endtask

  task automatic tick();
    logic [3:0] p;
    @(negedge clk);
    p = fifo_pop;
    @(posedge clk);
    #1;
    if (p[0]) void'(q0.pop_front());
    if (p[1]) void'(q1.pop_front());
    if (p[2]) void'(q2.pop_front());
    if (p[3]) void'(q3.pop_front());
    upd();
  endtask

  task automatic chk_word(input string tag, input logic [1:0] gid,
                          input logic lane, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(valid_out), 32'd1);
    chk({tag, ".gid"},   32'(grant_id),  32'(gid));
    chk({tag, ".lane"},  32'(lane_out),  32'(lane));
    chk({tag, ".data"},  32'(data_out),  32'(d));
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".valid"}, 32'(valid_out), 32'd0);
    chk({tag, ".data"},  32'(data_out),  32'd0);
    chk({tag, ".gid"},   32'(grant_id),  32'd0);
    chk({tag, ".lane"},  32'(lane_out),  32'd0);
    chk({tag, ".state"}, 32'(state_out), 32'd0);
    chk({tag, ".stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, ".pop"},   32'(fifo_pop),  32'd0);
  endtask

  task automatic run_abcd(input string tag);
    logic [7:0] exp_d[4];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB0;
    exp_d[2] = 8'hC0; exp_d[3] = 8'hD0;
    clrq();
    q0.push_back(8'hA0); q1.push_back(8'hB0);
    q2.push_back(8'hC0); q3.push_back(8'hD0);
    upd();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_word($sformatf("%s%0d", tag, i), 2'(i), 1'(i % 2), exp_d[i]);
    end
    tick();
    chk({tag, ".end_valid"}, 32'(valid_out), 32'd0);
    chk({tag, ".end_state"}, 32'(state_out), 32'd0);
  endtask

  initial begin
    reset_L = 1'b1;
    arb_en  = 1'b1;
    dest_af = 2'b00;
    clrq();
    #2 reset_L = 1'b0;
    #1 chk_rst("rst0");
    @(posedge clk);
    #2 reset_L = 1'b1;

    run_abcd("abcd");

    q2.push_back(8'h11); q2.push_back(8'h22); q2.push_back(8'h33);
    upd();
    tick(); chk_word("single0", 2'd2, 1'b0, 8'h11);
    tick(); chk_word("single1", 2'd2, 1'b1, 8'h22);
    tick(); chk_word("single2", 2'd2, 1'b0, 8'h33);
    chk("single.state", 32'(state_out), 32'd1);
    tick();
    chk("single.end_valid", 32'(valid_out), 32'd0);
    chk("single.end_state", 32'(state_out), 32'd0);

    q0.push_back(8'h10); q0.push_back(8'h11);
    q1.push_back(8'h20); q1.push_back(8'h21);
    q2.push_back(8'h30); q2.push_back(8'h31);
    q3.push_back(8'h40); q3.push_back(8'h41);
    dest_af = 2'b01;
    upd();
    #1 chk("stall.pop_pre", 32'(fifo_pop), 32'b1000);
    tick(); chk_word("stall.w", 2'd3, 1'b1, 8'h40);
    #1 chk("stall.pop_blk", 32'(fifo_pop), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("stall%0d.valid", i), 32'(valid_out), 32'd0);
      chk($sformatf("stall%0d.state", i), 32'(state_out), 32'd2);
      chk($sformatf("stall%0d.cnt", i),   32'(stall_cnt), 32'(i));
      chk($sformatf("stall%0d.hold", i),  32'(data_out),  32'h40);
    end
    dest_af = 2'b00;
    #1 chk("stall.pop_resume", 32'(fifo_pop), 32'b0001);
    tick(); chk_word("resume", 2'd0, 1'b0, 8'h10);
    chk("resume.state", 32'(state_out), 32'd1);
    chk("resume.cnt",   32'(stall_cnt), 32'd3);

    tick(); chk_word("en.pre", 2'd1, 1'b1, 8'h20);
    arb_en = 1'b0;
    #1 chk("en.pop_off", 32'(fifo_pop), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("en.off%0d.valid", i), 32'(valid_out), 32'd0);
      chk($sformatf("en.off%0d.state", i), 32'(state_out), 32'd0);
    end
    chk("en.off.cnt", 32'(stall_cnt), 32'd3);
    arb_en = 1'b1;
    tick(); chk_word("en.r0", 2'd2, 1'b0, 8'h30);
    tick(); chk_word("en.r1", 2'd3, 1'b1, 8'h41);
    tick(); chk_word("en.r2", 2'd0, 1'b0, 8'h11);
    tick(); chk_word("en.r3", 2'd1, 1'b1, 8'h21);
    tick(); chk_word("en.r4", 2'd2, 1'b0, 8'h31);
    tick();
    chk("en.end_valid", 32'(valid_out), 32'd0);
    chk("en.left", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

    q0.push_back(8'h50); q1.push_back(8'h51);
    upd();
    tick(); chk_word("mid.w", 2'd0, 1'b1, 8'h50);
    reset_L = 1'b0;
    #1 chk_rst("rst_mid");
    #1 reset_L = 1'b1;
    run_abcd("rel");

    q0.push_back(8'h99);
    dest_af = 2'b01;
    upd();
    for (int i = 0; i < 255; i++) tick();
    chk("sat.cnt255", 32'(stall_cnt), 32'd255);
    chk("sat.state",  32'(state_out), 32'd2);
    for (int i = 0; i < 45; i++) tick();
    chk("sat.cnt300", 32'(stall_cnt), 32'd255);
    chk("sat.valid",  32'(valid_out), 32'd0);
    dest_af = 2'b10;
    #1 chk("other_lane.pop", 32'(fifo_pop), 32'b0001);
    tick(); chk_word("other_lane", 2'd0, 1'b0, 8'h99);
    chk("other_lane.cnt", 32'(stall_cnt), 32'd255);
    dest_af = 2'b00;

`ifdef ARB_BURST_EN
    begin
      logic [1:0] bg[8];
      logic [7:0] bd[8];
      reset_L = 1'b0;
      #1 reset_L = 1'b1;
      clrq();
      for (int i = 0; i < 6; i++) q0.push_back(8'(8'h60 + i));
      q1.push_back(8'h70); q1.push_back(8'h71);
      upd();
      bg = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
      bd = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h64, 8'h65};
      for (int i = 0; i < 8; i++) begin
        tick();
        chk_word($sformatf("burst%0d", i), bg[i], 1'(i % 2), bd[i]);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arb_rr4_demux_ctrl.md
# arb_rr4_demux_ctrl

Round-robin arbiter that shares the 8-bit valid-qualified bus feeding the 1:2 demux among four upstream requester FIFOs. It pops one word per cycle from the granted FIFO and tracks which demux lane the word will land on, mirroring the demux's toggling selector. It stalls when that lane's downstream FIFO is almost full. It sits between the four input FIFOs and the demux input (`data_in`/`valid_in`).

## Interface
Parameters:
- `DATA_W`, 8: word width.
- `BURST_LEN`, 4: maximum consecutive grants to one requester. Used only with `ARB_BURST_EN`; legal values 1..15.

Ports (the table's width column lists explicit bit widths; literal `[N:0]` notation is not used):
- `clk`, input, 1 bit: single clock. All state updates on the posedge.
- `reset_L`, input, 1 bit: asynchronous, active-low reset.
- `arb_en`, input, 1 bit: arbitration enable.
- `fifo_empty`, input, 4 bits: per-requester empty flag, one bit per requester.
- `fifo_data0` … `fifo_data3`, input, `DATA_W` bits each: show-ahead head word of each requester.
- `dest_af`, input, 2 bits: almost-full flag of demux output lane 0 and lane 1.
- `fifo_pop`, output, 4 bits: one-hot pop. Combinational (Mealy) in the grant cycle.
- `data_out`, output, `DATA_W` bits: registered word to the demux `data_in`.
- `valid_out`, output, 1 bit: registered valid to the demux `valid_in`.
- `lane_out`, output, 1 bit: demux lane that the current `data_out` targets.
- `grant_id`, output, 2 bits: registered index of the requester whose word is on `data_out`.
- `state_out`, output, 2 bits: FSM state encoding, IDLE=0, ACTIVE=1, STALL=2.
- `stall_cnt`, output, 8 bits: count of stall cycles. Saturates at 255.

## Operation
- `req[i] = ~fifo_empty[i] & arb_en`.
- `next_lane` register starts at 0 and toggles on every emitted word. It tracks the demux selector.
- `blocked = dest_af[next_lane]`.
- Grant selection: the first `req` bit at or after `ptr`, scanning upward modulo 4. `ptr` is 2 bits and resets to 0.
- When a grant is issued (`|req & ~blocked`):
  - `fifo_pop[g] = 1`.
  - At the edge: `data_out <= fifo_data[g]`, `valid_out <= 1`, `grant_id <= g`, `lane_out <= next_lane`, `next_lane <= ~next_lane`, `ptr <= g+1` (wraps 3→0).
- Otherwise:
  - `fifo_pop = 0`.
  - At the edge: `valid_out <= 0`. `data_out`, `grant_id`, and `lane_out` hold their values.
- FSM (registered):
  - IDLE → ACTIVE when a grant is issued.
  - IDLE → STALL when `|req & blocked`.
  - ACTIVE → IDLE when `~|req`.
  - ACTIVE → STALL when `|req & blocked`.
  - STALL → ACTIVE when a grant is issued.
  - STALL → IDLE when `~|req`.
- `stall_cnt` increments at each edge where `|req & blocked`. It holds at 255 and is cleared only by reset.
- Edge cases:
  - `arb_en` low stops pops immediately. `ptr` and `next_lane` are retained.
  - A lone requester receives a grant every cycle.
  - All four requesting gives the sequence 0,1,2,3,0,…
  - `dest_af` for the non-targeted lane is ignored.
- Reset (asynchronous, any time, including mid-burst) sets every output to 0 and sets the FSM to IDLE. `ptr`, `next_lane`, and the burst counter go to 0. No pop is issued while `reset_L = 0`.

## Timing
- Pop to `valid_out` latency: 1 cycle. The word popped at edge N appears on `data_out` after edge N.
- Throughput: 1 word per cycle with no bubbles while `req` is nonzero and the target lane is not blocked.
- `dest_af` is sampled combinationally in the same cycle. An assertion in cycle N blocks the pop in cycle N, so `valid_out = 0` after edge N.
- Reset is asynchronous on assertion. Release is synchronous to `clk`; the first grant is possible in the first cycle after release.
- No combinational path from any input to `data_out` or `valid_out`. `fifo_pop` depends combinationally on `fifo_empty`, `arb_en`, and `dest_af`.

## Configuration
- **`ARB_BURST_EN` defined:**
  - The owner keeps the grant while its FIFO is non-empty, the target lane is unblocked, and `burst_cnt < BURST_LEN`.
  - `burst_cnt` is 4 bits and increments per grant.
  - When the burst ends (count reached, or the owner's FIFO is empty), set `ptr <= owner+1` and clear `burst_cnt`.
  - A block mid-burst holds both owner and `burst_cnt`; the same owner resumes when unblocked.
  - `arb_en` low also ends the burst.
- **`ARB_BURST_EN` undefined:** rotation after every word (equivalent to `BURST_LEN = 1`). No burst counter is built.

## Test plan
- **Reset:** assert `reset_L = 0` mid-traffic. All outputs are 0 asynchronously and `state_out = 0`. After release with all FIFOs holding A0,B0,C0,D0, `grant_id` sequence is 0,1,2,3 and `lane_out` is 0,1,0,1.
- **Single requester:** only FIFO2 is non-empty, holding 0x11,0x22,0x33. `valid_out` is high for 3 consecutive cycles with `data_out` 0x11,0x22,0x33, then `state_out` returns to IDLE.
- **Stall:** all requesting and `dest_af = 2'b01`. When `next_lane = 0`, no pop, `valid_out = 0`, `state_out = 2`, and `stall_cnt` increments each cycle. Clearing `dest_af` resumes with the same `ptr` requester.
- **Saturation:** hold a block for 300 cycles. `stall_cnt` stops at 255.
- **Burst (`ARB_BURST_EN`, `BURST_LEN = 4`):** FIFO0 holds 6 words and FIFO1 holds 2. Grants are 0,0,0,0,1,1,0,0.
- **Enable:** deassert `arb_en` for 5 cycles mid-stream. No pops occur. Traffic resumes at the saved `ptr` and `next_lane` with no lost or duplicated words.
